reg_bank8_writer: RTL

- Write side of an 8-entry register bank, and the counterpart of the 8:1 read-select mux tree. A 3-bit write address is decoded to a one-hot enable, and the write data is stored into the selected entry.
- Accepts writes through a valid/ready handshake.
- Provides a sequential clear sweep that zeroes all entries one per cycle.
- Exposes all entries flattened, so the read-side mux tree selects from them.

---
 rtl/reg_bank8_writer_pkg.sv | 21 ++
 rtl/reg_bank8_writer_if.sv | 28 ++
 rtl/reg_bank8_writer_decoder3_8.sv | 16 +
 rtl/reg_bank8_writer.sv | 97 +++++++++
 4 files changed

// File: rtl/reg_bank8_writer_pkg.sv
// Shared constants and state encoding for the 8-entry register bank write side.
// Pure definitions: no latency, no flow control.
package reg_bank8_writer_pkg;

   localparam int NUM_ENTRIES = 8;
   localparam int ADDR_W      = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Mask that removes the hardwired-zero top entry from a write enable vector.
   function automatic logic [NUM_ENTRIES-1:0] keep_mask(input bit zero_last);
      logic [NUM_ENTRIES-1:0] m;
      m = '1;
      if (zero_last) m[NUM_ENTRIES-1] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/reg_bank8_writer_if.sv
// Write/clear handshake and flattened entry view of the register bank.
// Master drives requests; slave returns ready, busy, write strobe and entry contents.
interface reg_bank8_writer_if
   import reg_bank8_writer_pkg::*;
#(
   parameter int WIDTH = 64
);

   logic                         wr_valid;
   logic                         wr_ready;
   logic [ADDR_W-1:0]            wr_addr;
   logic [WIDTH-1:0]             wr_data;
   logic                         clr_req;
   logic                         busy;
   logic [NUM_ENTRIES-1:0]       wr_onehot;
   logic [NUM_ENTRIES*WIDTH-1:0] regs_flat;

   modport master (
      output wr_valid, wr_addr, wr_data, clr_req,
      input  wr_ready, busy, wr_onehot, regs_flat
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, clr_req,
      output wr_ready, busy, wr_onehot, regs_flat
   );

endinterface

// File: rtl/reg_bank8_writer_decoder3_8.sv
// 3-to-8 one-hot decoder with enable; mirror of the read-side 8:1 mux tree.
// Combinational, zero latency, no flow control.
module decoder3_8
   import reg_bank8_writer_pkg::*;
(
   input  logic                   en,
   input  logic [ADDR_W-1:0]      addr,
   output logic [NUM_ENTRIES-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/reg_bank8_writer.sv
// 8-entry register bank write side with a one-entry-per-cycle clear sweep.
// Writes land 1 cycle after handshake; wr_ready is low during a sweep and whenever clr_req is high.
module reg_bank8_writer
   import reg_bank8_writer_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter bit ZERO_LAST = 1'b1
)
(
   input logic               clk,
   input logic               reset,
   reg_bank8_writer_if.slave bus
);

   state_t                       state;
   state_t                       state_nxt;
   logic [ADDR_W-1:0]            cnt;
   logic [ADDR_W-1:0]            cnt_nxt;
   logic                         wr_ready;
   logic                         wr_fire;
   logic [NUM_ENTRIES-1:0]       dec_oh;
   logic [NUM_ENTRIES-1:0]       wr_en;
   logic [NUM_ENTRIES-1:0]       onehot_q;
   logic [NUM_ENTRIES*WIDTH-1:0] flat;

   // Clear has priority over a simultaneous write by gating ready.
   assign wr_ready = (state == IDLE) && !bus.clr_req;
   assign wr_fire  = bus.wr_valid && wr_ready;

   decoder3_8 u_dec (
      .en     (wr_fire),
      .addr   (bus.wr_addr),
      .onehot (dec_oh)
   );

   // A write to a hardwired-zero entry still completes the handshake but strobes nothing.
   assign wr_en = dec_oh & keep_mask(ZERO_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         onehot_q <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         onehot_q <= wr_en;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (bus.clr_req) state_nxt = CLEAR;
         end
         CLEAR: begin
            // The 3-bit wrap 7->0 coincides with the return to IDLE.
            cnt_nxt = cnt + 1'b1;
            if (cnt == ADDR_W'(NUM_ENTRIES - 1)) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
      if (ZERO_LAST && (i == NUM_ENTRIES - 1)) begin : g_zero
         assign flat[i*WIDTH +: WIDTH] = '0;
      end else begin : g_reg
         logic [WIDTH-1:0] q;
         logic             clr_hit;

         assign clr_hit = (state == CLEAR) && (cnt == ADDR_W'(i));

         always_ff @(posedge clk) begin
            if (reset || clr_hit) begin
               q <= '0;
            end else if (wr_en[i]) begin
               q <= bus.wr_data;
            end
         end

         assign flat[i*WIDTH +: WIDTH] = q;
      end
   end

   assign bus.wr_ready  = wr_ready;
   assign bus.busy      = (state == CLEAR);
   assign bus.wr_onehot = onehot_q;
   assign bus.regs_flat = flat;

endmodule
